// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use hazard detection and event counters
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [6:0]        id_ctrl,
    input  logic [3:0]        id_aluctrl,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              flush,
    output logic              ex_valid,
    output logic [6:0]        ex_ctrl,
    output logic [3:0]        ex_aluctrl,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // control word bit positions: {RegWrite,RegDst,ALUSrc,Branch,MemWrite,MemtoReg,Jump}
    localparam int REGWRITE = 6;
    localparam int MEMTOREG = 1;

    logic haz;
    logic bubble;

    // a load in EX whose destination is read by the ID instruction
    assign haz = ex_valid & ex_ctrl[MEMTOREG] & ex_ctrl[REGWRITE] & (ex_rt != '0)
               & id_valid & ((ex_rt == id_rs) | (ex_rt == id_rt));

    assign stall  = haz & ~flush;
    assign bubble = flush | stall | ~id_valid;

    // bubbles load constant zeros so an undecodable control word never reaches EX
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid   <= 1'b0;
            ex_ctrl    <= '0;
            ex_aluctrl <= '0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            ex_pc4     <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_rd      <= '0;
        end else if (bubble) begin
            ex_valid   <= 1'b0;
            ex_ctrl    <= '0;
            ex_aluctrl <= '0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            ex_pc4     <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_rd      <= '0;
        end else begin
            ex_valid   <= 1'b1;
            ex_ctrl    <= id_ctrl;
            ex_aluctrl <= id_aluctrl;
            ex_rs_data <= id_rs_data;
            ex_rt_data <= id_rt_data;
            ex_imm     <= id_imm;
            ex_pc4     <= id_pc4;
            ex_rs      <= id_rs;
            ex_rt      <= id_rt;
            ex_rd      <= id_rd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [6:0]  id_ctrl;
    logic [3:0]  id_aluctrl;
    logic [31:0] id_rs_data, id_rt_data, id_imm, id_pc4;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        flush;

    logic        ex_valid, stall;
    logic [6:0]  ex_ctrl;
    logic [3:0]  ex_aluctrl;
    logic [31:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [15:0] stall_cnt, flush_cnt;

    logic        d2_valid, d2_stall;
    logic [6:0]  d2_ctrl;
    logic [3:0]  d2_aluctrl;
    logic [31:0] d2_rs_data, d2_rt_data, d2_imm, d2_pc4;
    logic [4:0]  d2_rs, d2_rt, d2_rd;
    logic [1:0]  d2_stall_cnt, d2_flush_cnt;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_aluctrl(id_aluctrl), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_pc4(id_pc4), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .flush(flush), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_aluctrl(ex_aluctrl),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .stall(stall),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    id_ex_stage #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_aluctrl(id_aluctrl), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_pc4(id_pc4), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .flush(flush), .ex_valid(d2_valid), .ex_ctrl(d2_ctrl), .ex_aluctrl(d2_aluctrl),
        .ex_rs_data(d2_rs_data), .ex_rt_data(d2_rt_data), .ex_imm(d2_imm), .ex_pc4(d2_pc4),
        .ex_rs(d2_rs), .ex_rt(d2_rt), .ex_rd(d2_rd), .stall(d2_stall),
        .stall_cnt(d2_stall_cnt), .flush_cnt(d2_flush_cnt)
    );

    typedef struct {
        logic        v;
        logic [6:0]  ctrl;
        logic [3:0]  alu;
        logic [31:0] rsd, rtd, imm, pc4;
        logic [4:0]  rs, rt, rd;
        logic [15:0] sc, fc;
        logic [1:0]  fc2;
    } exp_t;

    exp_t sbq[$];

    int total = 0;
    int bad   = 0;

    // reference model state: what EX should hold, and counter values
    logic       m_v;
    logic [6:0] m_ctrl;
    logic [4:0] m_rt;
    int         msc, mfc, mfc2;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_v = 1'b0; m_ctrl = '0; m_rt = '0;
        msc = 0; mfc = 0; mfc2 = 0;
        sbq.delete();
    endtask

    task automatic drive(input logic v, input logic [6:0] c, input logic [3:0] a,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] imm, input logic fl);
        id_valid   = v;
        id_ctrl    = c;
        id_aluctrl = a;
        id_rs      = rs;
        id_rt      = rt;
        id_rd      = rd;
        id_imm     = imm;
        id_rs_data = $urandom;
        id_rt_data = $urandom;
        id_pc4     = $urandom;
        flush      = fl;
    endtask

    // predict, check stall, clock once, compare EX against the scoreboard
    task automatic step(output logic exp_stall);
        exp_t e;
        logic haz;
        haz = m_v & m_ctrl[1] & m_ctrl[6] & (m_rt != 5'd0) & id_valid
            & ((m_rt == id_rs) | (m_rt == id_rt));
        exp_stall = haz & ~flush;
        #1 check("stall", {127'd0, stall}, {127'd0, exp_stall});
        e = '{default: '0};
        if (flush) begin
            if (mfc < 65535) mfc++;
            if (mfc2 < 3) mfc2++;
        end else if (haz) begin
            if (msc < 65535) msc++;
        end else if (id_valid) begin
            e.v = 1'b1; e.ctrl = id_ctrl; e.alu = id_aluctrl;
            e.rsd = id_rs_data; e.rtd = id_rt_data; e.imm = id_imm; e.pc4 = id_pc4;
            e.rs = id_rs; e.rt = id_rt; e.rd = id_rd;
        end
        e.sc = msc[15:0]; e.fc = mfc[15:0]; e.fc2 = mfc2[1:0];
        sbq.push_back(e);
        m_v = e.v; m_ctrl = e.ctrl; m_rt = e.rt;
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        check("ex_valid", {127'd0, ex_valid}, {127'd0, e.v});
        check("ex_ctrl", {121'd0, ex_ctrl}, {121'd0, e.ctrl});
        check("ex_aluctrl", {124'd0, ex_aluctrl}, {124'd0, e.alu});
        check("ex_regs", {113'd0, ex_rs, ex_rt, ex_rd}, {113'd0, e.rs, e.rt, e.rd});
        check("ex_data", {ex_rs_data, ex_rt_data, ex_imm, ex_pc4}, {e.rsd, e.rtd, e.imm, e.pc4});
        check("stall_cnt", {112'd0, stall_cnt}, {112'd0, e.sc});
        check("flush_cnt", {112'd0, flush_cnt}, {112'd0, e.fc});
        check("flush_cnt_w2", {126'd0, d2_flush_cnt}, {126'd0, e.fc2});
        @(negedge clk);
    endtask

    localparam logic [6:0] C_ADDI = 7'b1010000;
    localparam logic [6:0] C_LW   = 7'b1010010;
    localparam logic [6:0] C_ADD  = 7'b1100000;

    initial begin
        logic st;
        logic hold;
        reset = 1'b1;
        drive(1'b0, 7'd0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
        model_clear();
        repeat (2) @(negedge clk);
        check("rst_valid", {127'd0, ex_valid}, 128'd0);
        check("rst_fields", {ex_ctrl, ex_aluctrl, ex_rs, ex_rt, ex_rd, ex_imm, 53'd0}, 128'd0);
        check("rst_stall", {127'd0, stall}, 128'd0);
        check("rst_cnts", {96'd0, stall_cnt, flush_cnt}, 128'd0);
        reset = 1'b0;

        // addi
        drive(1'b1, C_ADDI, 4'b0010, 5'd1, 5'd2, 5'd0, 32'd5, 1'b0); step(st);
        // lw $8 then add $9,$8,$1: one stall cycle, then add enters EX
        drive(1'b1, C_LW, 4'b0010, 5'd1, 5'd8, 5'd0, 32'd4, 1'b0);    step(st);
        drive(1'b1, C_ADD, 4'b0010, 5'd8, 5'd1, 5'd9, 32'd0, 1'b0);   step(st);
        check("lu_stall_seen", {127'd0, st}, {127'd0, 1'b1});
        step(st);
        // lw $0 then use of $0; lw $8 then unrelated registers
        drive(1'b1, C_LW, 4'b0010, 5'd1, 5'd0, 5'd0, 32'd8, 1'b0);    step(st);
        drive(1'b1, C_ADD, 4'b0010, 5'd0, 5'd0, 5'd5, 32'd0, 1'b0);   step(st);
        drive(1'b1, C_LW, 4'b0010, 5'd1, 5'd8, 5'd0, 32'd8, 1'b0);    step(st);
        drive(1'b1, C_ADD, 4'b0010, 5'd3, 5'd4, 5'd5, 32'd0, 1'b0);   step(st);
        // hazard coinciding with flush
        drive(1'b1, C_LW, 4'b0010, 5'd1, 5'd8, 5'd0, 32'd8, 1'b0);    step(st);
        drive(1'b1, C_ADD, 4'b0010, 5'd8, 5'd2, 5'd5, 32'd0, 1'b1);   step(st);

        // asynchronous reset while a stall is pending
        drive(1'b1, C_LW, 4'b0010, 5'd1, 5'd8, 5'd0, 32'd8, 1'b0);    step(st);
        drive(1'b1, C_ADD, 4'b0010, 5'd8, 5'd2, 5'd5, 32'd0, 1'b0);
        #1 check("pre_rst_stall", {127'd0, stall}, {127'd0, 1'b1});
        #1 reset = 1'b1;
        #1;
        check("mid_rst_stall", {127'd0, stall}, 128'd0);
        check("mid_rst_valid", {127'd0, ex_valid}, 128'd0);
        check("mid_rst_fields", {ex_ctrl, ex_aluctrl, ex_rs, ex_rt, ex_rd, ex_imm, 53'd0}, 128'd0);
        check("mid_rst_cnts", {96'd0, stall_cnt, flush_cnt}, 128'd0);
        model_clear();
        @(negedge clk);
        reset = 1'b0;

        // five consecutive flushes: narrow counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, C_ADDI, 4'b0010, 5'd1, 5'd2, 5'd3, 32'd7, 1'b1);
            step(st);
        end

        // unknown control word on a squashed or invalid instruction
        drive(1'b0, 7'bxxxxxxx, 4'bxxxx, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0); step(st);
        drive(1'b1, 7'bxxxxxxx, 4'bxxxx, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1); step(st);

        // random traffic; a stalled instruction is re-presented unchanged
        hold = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (!hold) begin
                logic [6:0] c;
                c = 7'($urandom);
                if ($urandom_range(0, 1) == 0) begin
                    c[6] = 1'b1;
                    c[1] = 1'b1;
                end
                drive($urandom_range(0, 3) != 0, c, 4'($urandom), 5'($urandom_range(0, 3)),
                      5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom,
                      $urandom_range(0, 7) == 0);
            end else begin
                flush = ($urandom_range(0, 7) == 0);
            end
            step(st);
            hold = st;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
